// File: rtl/display_digit_scanner_if.sv
// Bus bundle between the scan controller and its driver.
// Carries the display value/strobe/enables in and the scan outputs back.
interface display_digit_scanner_if #(
    parameter int NUM_DIGITS = 8
);
    localparam int IW = $clog2(NUM_DIGITS);

    logic [4*NUM_DIGITS-1:0] value_in;
    logic                    load;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [3:0]              nibble_out;
    logic [NUM_DIGITS-1:0]   anodes;
    logic [IW-1:0]           digit_idx;
    logic                    frame_done;

    modport master (
        output value_in, load, digit_en,
        input  nibble_out, anodes, digit_idx, frame_done
    );

    modport slave (
        input  value_in, load, digit_en,
        output nibble_out, anodes, digit_idx, frame_done
    );
endinterface

// File: rtl/display_digit_scanner.sv
// Time-multiplexed 7-segment scan controller, double-buffered value.
// Optional leading-zero blanking: define DISPLAY_SCANNER_LZB_EN.
module display_digit_scanner #(
    parameter int NUM_DIGITS      = 8,
    parameter int TICKS_PER_DIGIT = 100000,
    parameter int GUARD_TICKS     = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    display_digit_scanner_if.slave   scan
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(TICKS_PER_DIGIT);

    logic [CW-1:0]           tick_cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] pend_val;
    logic                    pend_flag;
    logic                    frame_done;

    logic                    tick_end;
    logic                    frame_end;
    logic                    guard_done;
    logic [NUM_DIGITS-1:0]   visible;

    assign tick_end  = (tick_cnt == CW'(TICKS_PER_DIGIT - 1));
    assign frame_end = tick_end && (idx == IW'(NUM_DIGITS - 1));

    generate
        if (GUARD_TICKS == 0) begin : g_noguard
            assign guard_done = 1'b1;
        end else begin : g_guard
            assign guard_done = (tick_cnt >= CW'(GUARD_TICKS));
        end
    endgenerate

    // Slot counters, frame pulse and the double-buffered display value
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick_cnt   <= '0;
            idx        <= '0;
            shadow     <= '0;
            pend_val   <= '0;
            pend_flag  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (tick_end) begin
                tick_cnt <= '0;
                if (idx == IW'(NUM_DIGITS - 1))
                    idx <= '0;
                else
                    idx <= idx + 1'b1;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
            if (frame_end) begin
                if (scan.load)
                    shadow <= scan.value_in;
                else if (pend_flag)
                    shadow <= pend_val;
                pend_flag <= 1'b0;
            end else if (scan.load) begin
                pend_val  <= scan.value_in;
                pend_flag <= 1'b1;
            end
        end
    end

`ifdef DISPLAY_SCANNER_LZB_EN
    // Blank digits above the most significant nonzero nibble; digit 0 always shown
    always_comb begin : lzb
        logic seen;
        seen       = 1'b0;
        visible    = '0;
        visible[0] = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            seen       = seen | (shadow[4*k +: 4] != 4'h0);
            visible[k] = seen;
        end
    end
`else
    assign visible = '1;
`endif

    // Select the current digit's nibble and light its anode after the guard
    always_comb begin
        scan.nibble_out = 4'h0;
        scan.anodes     = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                scan.nibble_out = shadow[4*k +: 4];
                if (guard_done && scan.digit_en[k] && visible[k])
                    scan.anodes[k] = 1'b0;
            end
        end
    end

    assign scan.digit_idx  = idx;
    assign scan.frame_done = frame_done;

endmodule

// File: tb/tb_display_digit_scanner.sv
// Directed table-driven bench for display_digit_scanner.
// Runs with NUM_DIGITS=4, TICKS_PER_DIGIT=8, GUARD_TICKS=2.
module tb_display_digit_scanner;
    localparam int ND  = 4;
    localparam int TPD = 8;
    localparam int GT  = 2;
`ifdef DISPLAY_SCANNER_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    display_digit_scanner_if #(.NUM_DIGITS(ND)) scan ();

    display_digit_scanner #(
        .NUM_DIGITS     (ND),
        .TICKS_PER_DIGIT(TPD),
        .GUARD_TICKS    (GT)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .scan   (scan.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        ld;
        logic [15:0] val;
        logic [3:0]  an;
        logic [3:0]  nib;
        logic [1:0]  idx;
        logic        fd;
    } vec_t;

    vec_t tv[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t v(int c, logic [3:0] an, logic [3:0] nib,
                               logic [1:0] idx, logic fd = 1'b0,
                               logic ld = 1'b0, logic [15:0] val = 16'h0);
        vec_t r;
        r.cyc = c; r.an = an; r.nib = nib; r.idx = idx;
        r.fd = fd; r.ld = ld; r.val = val;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [3:0] an, logic [3:0] nib,
                         logic [1:0] idx, logic fd);
        checks++;
        if (scan.anodes !== an || scan.nibble_out !== nib ||
            scan.digit_idx !== idx || scan.frame_done !== fd) begin
            errors++;
            $display("FAIL %s: got an=%b nib=%h idx=%0d fd=%b want an=%b nib=%h idx=%0d fd=%b",
                     name, scan.anodes, scan.nibble_out, scan.digit_idx,
                     scan.frame_done, an, nib, idx, fd);
        end
    endtask

    task automatic check_int(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic do_reset(logic [3:0] en);
        reset_n       = 1'b0;
        scan.load     = 1'b0;
        scan.value_in = 16'h0;
        scan.digit_en = en;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("reset%0d", i), 4'hF, 4'h0, 2'd0, 1'b0);
        end
        reset_n = 1'b1;
    endtask

    task automatic run_table(string name, int last);
        int p = 0;
        for (int c = 0; c <= last; c++) begin
            scan.load = 1'b0;
            while (p < tv.size() && tv[p].cyc == c) begin
                scan.load = tv[p].ld;
                if (tv[p].ld)
                    scan.value_in = tv[p].val;
                check($sformatf("%s_c%0d", name, c),
                      tv[p].an, tv[p].nib, tv[p].idx, tv[p].fd);
                p++;
            end
            step();
        end
        scan.load = 1'b0;
    endtask

    function automatic logic [3:0] lit(int k);
        logic [3:0] m;
        m    = 4'hF;
        m[k] = 1'b0;
        return m;
    endfunction

    initial begin
        scan.load     = 1'b0;
        scan.value_in = 16'h0;
        scan.digit_en = 4'hF;

        // Reset, guard timing, first frame pulse, mid-frame load
        do_reset(4'hF);
        tv.delete();
        tv.push_back(v(0,  4'hF, 4'h0, 2'd0));
        tv.push_back(v(1,  4'hF, 4'h0, 2'd0));
        tv.push_back(v(2,  lit(0), 4'h0, 2'd0));
        tv.push_back(v(5,  lit(0), 4'h0, 2'd0, 1'b0, 1'b1, 16'h1234));
        tv.push_back(v(7,  lit(0), 4'h0, 2'd0));
        tv.push_back(v(8,  4'hF, 4'h0, 2'd1));
        tv.push_back(v(9,  4'hF, 4'h0, 2'd1));
        tv.push_back(v(10, lit(1), 4'h0, 2'd1));
        tv.push_back(v(15, lit(1), 4'h0, 2'd1));
        tv.push_back(v(18, lit(2), 4'h0, 2'd2));
        tv.push_back(v(26, lit(3), 4'h0, 2'd3));
        tv.push_back(v(31, lit(3), 4'h0, 2'd3));
        tv.push_back(v(32, 4'hF, 4'h4, 2'd0, 1'b1));
        tv.push_back(v(33, 4'hF, 4'h4, 2'd0));
        tv.push_back(v(34, lit(0), 4'h4, 2'd0));
        tv.push_back(v(42, lit(1), 4'h3, 2'd1));
        tv.push_back(v(50, lit(2), 4'h2, 2'd2));
        tv.push_back(v(58, lit(3), 4'h1, 2'd3));
        tv.push_back(v(64, 4'hF, 4'h4, 2'd0, 1'b1));
        run_table("basic", 64);

        // Two loads in one frame: last one wins
        do_reset(4'hF);
        tv.delete();
        tv.push_back(v(3,  lit(0), 4'h0, 2'd0, 1'b0, 1'b1, 16'hAAAA));
        tv.push_back(v(8,  4'hF, 4'h0, 2'd1));
        tv.push_back(v(20, lit(2), 4'h0, 2'd2, 1'b0, 1'b1, 16'h5555));
        tv.push_back(v(31, lit(3), 4'h0, 2'd3));
        tv.push_back(v(32, 4'hF, 4'h5, 2'd0, 1'b1));
        tv.push_back(v(42, lit(1), 4'h5, 2'd1));
        tv.push_back(v(50, lit(2), 4'h5, 2'd2));
        tv.push_back(v(58, lit(3), 4'h5, 2'd3));
        run_table("dbl", 58);

        // Frame-end loads, then blanking patterns
        do_reset(4'hF);
        tv.delete();
        tv.push_back(v(31,  lit(3), 4'h0, 2'd3, 1'b0, 1'b1, 16'hBEEF));
        tv.push_back(v(32,  4'hF, 4'hF, 2'd0, 1'b1));
        tv.push_back(v(34,  lit(0), 4'hF, 2'd0));
        tv.push_back(v(42,  lit(1), 4'hE, 2'd1));
        tv.push_back(v(50,  lit(2), 4'hE, 2'd2));
        tv.push_back(v(58,  lit(3), 4'hB, 2'd3));
        tv.push_back(v(64,  4'hF, 4'hF, 2'd0, 1'b1));
        tv.push_back(v(66,  lit(0), 4'hF, 2'd0));
        tv.push_back(v(95,  lit(3), 4'hB, 2'd3, 1'b0, 1'b1, 16'h0030));
        tv.push_back(v(96,  4'hF, 4'h0, 2'd0, 1'b1));
        tv.push_back(v(98,  lit(0), 4'h0, 2'd0));
        tv.push_back(v(106, lit(1), 4'h3, 2'd1));
        tv.push_back(v(114, LZB ? 4'hF : lit(2), 4'h0, 2'd2));
        tv.push_back(v(122, LZB ? 4'hF : lit(3), 4'h0, 2'd3));
        tv.push_back(v(127, LZB ? 4'hF : lit(3), 4'h0, 2'd3, 1'b0, 1'b1, 16'h0000));
        tv.push_back(v(128, 4'hF, 4'h0, 2'd0, 1'b1));
        tv.push_back(v(130, lit(0), 4'h0, 2'd0));
        tv.push_back(v(138, LZB ? 4'hF : lit(1), 4'h0, 2'd1));
        tv.push_back(v(146, LZB ? 4'hF : lit(2), 4'h0, 2'd2));
        tv.push_back(v(154, LZB ? 4'hF : lit(3), 4'h0, 2'd3));
        run_table("fend", 154);

        // Digit mask 0101 over two frames, every cycle against a model
        begin
            logic [3:0] en;
            logic [3:0] exp_an;
            int low0 = 0;
            int low2 = 0;
            int low13 = 0;
            en = 4'b0101;
            do_reset(en);
            for (int c = 0; c < 2 * ND * TPD; c++) begin
                exp_an = 4'hF;
                if ((c % TPD) >= GT && en[(c / TPD) % ND])
                    exp_an[(c / TPD) % ND] = 1'b0;
                check($sformatf("mask_c%0d", c), exp_an, 4'h0,
                      2'((c / TPD) % ND), c == ND * TPD);
                low0  += int'(!scan.anodes[0]);
                low2  += int'(!scan.anodes[2]);
                low13 += int'(!scan.anodes[1]) + int'(!scan.anodes[3]);
                step();
            end
            check_int("mask_low0", low0, 2 * (TPD - GT));
            check_int("mask_low2", low2, 2 * (TPD - GT));
            check_int("mask_low13", low13, 0);
        end

        // Reset mid-frame discards a pending load
        do_reset(4'hF);
        for (int c = 0; c < 12; c++) begin
            scan.load     = (c == 5);
            scan.value_in = 16'h1234;
            step();
        end
        scan.load = 1'b0;
        do_reset(4'hF);
        for (int c = 0; c <= 34; c++) begin
            if (c == 32)
                check("rstpend_c32", 4'hF, 4'h0, 2'd0, 1'b1);
            if (c == 34)
                check("rstpend_c34", lit(0), 4'h0, 2'd0, 1'b0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
